// File: rtl/pfiform_param.sv
// ============================================================================
// Module   : pfiform_param
// Summary  : Variable-rate element gearbox FIFO (1..LANES in, 1..LANES out)
//            over a DEPTH-entry circular buffer with occupancy reporting.
//            Optional drain/flush mode enabled by macro PFIFORM_FLUSH_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pfiform_param #(
    parameter int ELEM_W = 6,
    parameter int LANES  = 32,
    parameter int DEPTH  = 128,
    parameter int CNT_W  = $clog2(LANES),
    parameter int OCC_W  = $clog2(DEPTH) + 1
) (
    input  logic                      i_core_clk,
    input  logic                      i_rx_rst,
    input  logic                      JoinEnable,
    output logic                      JoinPermit,
    input  logic [CNT_W-1:0]          JoinAmout,
    input  logic [ELEM_W*LANES-1:0]   JoinData,
    input  logic                      PopPermit,
    input  logic [CNT_W-1:0]          PopAmout,
    output logic                      PopEnable,
    output logic [ELEM_W*LANES-1:0]   PopData,
    output logic [OCC_W-1:0]          Occupancy
`ifdef PFIFORM_FLUSH_EN
    ,
    input  logic                      Flush,
    output logic                      FlushDone,
    output logic [CNT_W:0]            PopCount
`endif
);

    localparam int               PTR_W        = $clog2(DEPTH);
    localparam logic [OCC_W-1:0] c_JOIN_LIMIT = OCC_W'(DEPTH - LANES);

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_DRAIN  = 1'b1
    } state_t;

    logic [ELEM_W-1:0]        r_mem_q [DEPTH];
    logic [ELEM_W-1:0]        w_mem_d [DEPTH];
    logic [PTR_W-1:0]         r_wr_ptr_q, w_wr_ptr_d;
    logic [PTR_W-1:0]         r_rd_ptr_q, w_rd_ptr_d;
    logic [OCC_W-1:0]         r_occ_q, w_occ_d;
    logic                     r_join_permit_q, w_join_permit_d;
    logic                     r_pop_en_q, w_pop_en_d;
    logic [ELEM_W*LANES-1:0]  r_pop_data_q, w_pop_data_d;
    state_t                   r_state_q, w_state_d;
    logic [CNT_W:0]           w_join_n;
    logic [CNT_W:0]           w_pop_req;
    logic [CNT_W:0]           w_pop_n;
`ifdef PFIFORM_FLUSH_EN
    logic                     r_flush_done_q, w_flush_done_d;
    logic [CNT_W:0]           r_pop_cnt_q, w_pop_cnt_d;
`endif

    always_comb begin
        w_mem_d      = r_mem_q;
        w_state_d    = r_state_q;
        w_pop_en_d   = 1'b0;
        w_pop_data_d = r_pop_data_q;
        w_pop_req    = {1'b0, PopAmout} + 1'b1;
        w_pop_n      = '0;
        w_join_n     = '0;
`ifdef PFIFORM_FLUSH_EN
        w_flush_done_d = 1'b0;
        w_pop_cnt_d    = r_pop_cnt_q;
`endif
        if (JoinEnable && r_join_permit_q && (r_state_q == ST_NORMAL)) begin
            w_join_n = {1'b0, JoinAmout} + 1'b1;
        end

        // Pop decision sees only pre-edge occupancy; same-cycle joins do not count.
        if (PopPermit) begin
            if (r_occ_q >= OCC_W'(w_pop_req)) begin
                w_pop_n = w_pop_req;
            end else if (r_state_q == ST_DRAIN) begin
                w_pop_n = (CNT_W+1)'(r_occ_q);
            end
        end

        for (int k = 0; k < LANES; k++) begin
            if ((w_join_n != '0) && (CNT_W'(k) <= JoinAmout)) begin
                w_mem_d[r_wr_ptr_q + PTR_W'(k)] = JoinData[ELEM_W*k +: ELEM_W];
            end
        end

        if (w_pop_n != '0) begin
            w_pop_en_d   = 1'b1;
            w_pop_data_d = '0;
            for (int k = 0; k < LANES; k++) begin
                if ((CNT_W+1)'(k) < w_pop_n) begin
                    w_pop_data_d[ELEM_W*k +: ELEM_W] = r_mem_q[r_rd_ptr_q + PTR_W'(k)];
                end
            end
`ifdef PFIFORM_FLUSH_EN
            w_pop_cnt_d = w_pop_n;
`endif
        end

        w_wr_ptr_d = r_wr_ptr_q + PTR_W'(w_join_n);
        w_rd_ptr_d = r_rd_ptr_q + PTR_W'(w_pop_n);
        w_occ_d    = r_occ_q + OCC_W'(w_join_n) - OCC_W'(w_pop_n);

`ifdef PFIFORM_FLUSH_EN
        case (r_state_q)
            ST_NORMAL: begin
                if (Flush) begin
                    if (w_occ_d == '0) begin
                        w_flush_done_d = 1'b1;
                    end else begin
                        w_state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_occ_d == '0) begin
                    w_flush_done_d = 1'b1;
                    w_state_d      = ST_NORMAL;
                end
            end
            default: w_state_d = ST_NORMAL;
        endcase
`endif

        // Reserving a full beat of space keeps overflow impossible.
        w_join_permit_d = (w_state_d == ST_NORMAL) && (w_occ_d <= c_JOIN_LIMIT);
    end

    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            r_wr_ptr_q      <= '0;
            r_rd_ptr_q      <= '0;
            r_occ_q         <= '0;
            r_join_permit_q <= 1'b0;
            r_pop_en_q      <= 1'b0;
            r_pop_data_q    <= '0;
            r_state_q       <= ST_NORMAL;
`ifdef PFIFORM_FLUSH_EN
            r_flush_done_q  <= 1'b0;
            r_pop_cnt_q     <= '0;
`endif
        end else begin
            r_wr_ptr_q      <= w_wr_ptr_d;
            r_rd_ptr_q      <= w_rd_ptr_d;
            r_occ_q         <= w_occ_d;
            r_join_permit_q <= w_join_permit_d;
            r_pop_en_q      <= w_pop_en_d;
            r_pop_data_q    <= w_pop_data_d;
            r_state_q       <= w_state_d;
`ifdef PFIFORM_FLUSH_EN
            r_flush_done_q  <= w_flush_done_d;
            r_pop_cnt_q     <= w_pop_cnt_d;
`endif
        end
    end

    // Buffer contents are don't-care after reset, so the array is not reset.
    always_ff @(posedge i_core_clk) begin
        r_mem_q <= w_mem_d;
    end

    assign JoinPermit = r_join_permit_q;
    assign PopEnable  = r_pop_en_q;
    assign PopData    = r_pop_data_q;
    assign Occupancy  = r_occ_q;
`ifdef PFIFORM_FLUSH_EN
    assign FlushDone  = r_flush_done_q;
    assign PopCount   = r_pop_cnt_q;
`endif

endmodule

`default_nettype wire

// File: doc/pfiform_param.md
Name: pfiform_param

Overview:
Parametrised successor of the PFIFORM variable-rate element FIFO (gearbox) in the receive datapath.
- Each cycle accepts 1..LANES elements of ELEM_W bits on the join side.
- Each cycle emits 1..LANES elements on the pop side, with independent per-cycle amounts.
- Storage is a circular element buffer of DEPTH entries.
- Adds parametrised geometry, an occupancy output and an optional drain/flush mode.

Parameters:
ELEM_W, 6, bits per element
LANES, 32, max elements per join/pop beat
DEPTH, 128, buffer capacity in elements; power of two, >= 2*LANES
CNT_W, $clog2(LANES), width of amount fields (amount encoded as count-1)
OCC_W, $clog2(DEPTH)+1, occupancy width

Ports:
i_core_clk  in  1  clock
i_rx_rst  in  1  reset, synchronous, active-high
JoinEnable  in  1  join request
JoinPermit  out  1  space for a full LANES beat available
JoinAmout  in  CNT_W  elements in this join beat minus 1
JoinData  in  ELEM_W*LANES  element k at [ELEM_W*k +: ELEM_W]; element 0 is oldest
PopPermit  in  1  downstream ready
PopAmout  in  CNT_W  elements requested per pop minus 1
PopEnable  out  1  PopData valid this cycle
PopData  out  ELEM_W*LANES  popped elements; lane 0 is oldest
Occupancy  out  OCC_W  stored element count

Behaviour:
- Reset (i_rx_rst high at edge):
  - wr_ptr, rd_ptr and Occupancy reset to 0.
  - PopEnable=0, PopData=0, JoinPermit=0.
  - Buffer contents are don't-care.
  - A mid-operation reset discards all data. JoinPermit=1 on the first edge after reset is released.
- Join: accepted when JoinEnable && JoinPermit.
  - Elements 0..JoinAmout are written at wr_ptr..wr_ptr+JoinAmout, modulo DEPTH.
  - Lanes above JoinAmout are ignored.
  - jn = JoinAmout+1 if accepted, else 0.
- Pop: pn = PopAmout+1 when PopPermit && Occupancy >= PopAmout+1, else 0. The decision uses the pre-edge Occupancy; same-cycle joins are not visible.
  - When pn>0, PopData and PopEnable=1 are registered on that edge (1-cycle latency).
  - PopData lanes 0..PopAmout carry rd_ptr..rd_ptr+PopAmout; lanes above are 0. rd_ptr += pn.
  - Otherwise PopEnable=0 and PopData holds its last value.
- Occupancy_next = Occupancy + jn - pn. Simultaneous join and pop are both honoured.
- JoinPermit is registered: 1 iff DEPTH - Occupancy_next >= LANES. This is conservative, so overflow is impossible.
- Pointers wrap modulo DEPTH with no bubble; beats straddling the wrap are contiguous.
- JoinAmout and PopAmout may change every cycle; element order is always preserved.
- Residual data (< PopAmout+1 elements) stays buffered until enough data arrives or PopAmout decreases.
- JoinEnable while JoinPermit=0 is ignored with no state change.
- FSM: NORMAL and DRAIN. DRAIN is reachable only with the optional feature; without it the FSM stays in NORMAL.

Optional Feature:
Macro PFIFORM_FLUSH_EN.

Defined:
- Adds ports Flush (in, 1), FlushDone (out, 1) and PopCount (out, CNT_W+1).
- A Flush pulse in NORMAL enters DRAIN on the next edge. In DRAIN, JoinPermit=0 and joins are ignored.
- Each PopPermit cycle pops min(Occupancy, PopAmout+1) elements. PopCount gives the valid lane count; unused lanes are 0.
- When Occupancy reaches 0, FlushDone pulses for 1 cycle and the FSM returns to NORMAL.
- Flush in DRAIN is ignored. Flush with Occupancy=0 gives FlushDone on the next edge.
- In NORMAL, PopCount = PopAmout+1 when PopEnable=1.
- Reset aborts DRAIN.

Undefined:
- These ports are absent, the FSM is fixed in NORMAL, and a residual is held indefinitely.

Test Plan:
1. Release reset, all inputs idle -> JoinPermit=1 one cycle later; PopEnable=0, Occupancy=0, PopData=0.
2. JoinAmout=10, PopAmout=19, PopPermit=1, element values incrementing mod 64 -> first PopEnable after the 2nd join (22>=20). PopData lanes 0..19 = 0..19, lanes 20..31 = 0. The stream stays gap-free over 1000 cycles.
3. PopPermit=0, JoinAmout=31, JoinEnable held -> Occupancy 32/64/96/128. JoinPermit drops after the 4th join and further joins are ignored. Then PopPermit=1, PopAmout=31 -> four pops, each with the next 32 consecutive elements.
4. Continuous join 20 / pop 8 -> pointers wrap 128 repeatedly. The popped sequence is continuous across every wrap and Occupancy never exceeds 128.
5. Switch (JoinAmout, PopAmout) from (10,19) to (19,10) mid-stream -> no element lost or duplicated at the switch.
6. Reset asserted at Occupancy=70 -> Occupancy=0 and PopEnable=0 on that edge. With PFIFORM_FLUSH_EN: 13 elements left, PopAmout=7, Flush -> two pops with PopCount 8 then 5, then FlushDone.
